// File: rtl/resnet88_output_collector_if.sv
// resnet88_output_collector_if
// Bundles the lane capture inputs, the packed output stream and the status
// outputs of the resnet88 output collector. The collector connects through the
// master modport. The host/DMA side or a testbench connects through the slave
// modport.
interface resnet88_output_collector_if #(
  parameter int LANES  = 8,
  parameter int DATA_W = 16
);
  logic                      flush;
  logic [LANES-1:0]          lane_valid;
  logic [LANES*DATA_W-1:0]   lane_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*DATA_W-1:0]   out_data;
  logic [LANES-1:0]          overflow;
  logic [31:0]               word_count;

  modport master (
    input  flush, lane_valid, lane_data, out_ready,
    output out_valid, out_data, overflow, word_count
  );

  modport slave (
    output flush, lane_valid, lane_data, out_ready,
    input  out_valid, out_data, overflow, word_count
  );
endinterface

// File: rtl/resnet88_output_collector.sv
// resnet88_output_collector
// Each of the LANES output lanes of the resnet88 accelerator is captured into its
// own small FIFO. The lanes have no backpressure, so skew between them is
// absorbed by these FIFOs. When every lane holds a sample, the heads are popped
// together and packed into a one-entry output register. That register drives a
// valid/ready stream.
//
// Optional feature macro: RESNET88_COLLECTOR_STATS_EN
//   defined   : sticky per-lane overflow flags and a 32-bit accepted-word counter
//   undefined : overflow and word_count are tied to 0. The datapath is unchanged.
module resnet88_output_collector #(
  parameter int LANES  = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  resnet88_output_collector_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t                    state_q, state_d;
  logic [LANES*DATA_W-1:0]   out_data_q, out_data_d;
  logic [LANES*DATA_W-1:0]   head_data;
  logic [LANES-1:0]          lane_nonempty;
  logic [LANES-1:0]          lane_full;
  logic [LANES-1:0]          push_ok;
  logic                      load;

  // Per-lane FIFOs. All lanes pop together on load, so every packed word holds
  // the k-th sample of every lane. A full lane still accepts a push when it pops
  // on the same edge.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    assign lane_nonempty[gi] = (cnt_q != '0);
    assign lane_full[gi]     = (cnt_q == CW'(DEPTH));
    assign push_ok[gi]       = bus.lane_valid[gi] && (!lane_full[gi] || load);
    assign head_data[gi*DATA_W +: DATA_W] = mem_q[rd_ptr_q];

    // Next pointers and occupancy from this lane's push and the shared pop.
    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok[gi]) wr_ptr_d = wr_ptr_q + AW'(1);
      if (load)        rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + CW'(push_ok[gi]) - CW'(load);
    end

    // Pointer and occupancy registers. A flush empties the lane like a reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else if (bus.flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
      end
    end

    // Sample storage. It needs no reset because the occupancy marks it invalid.
    always_ff @(posedge clk) begin
      if (!bus.flush && push_ok[gi]) begin
        mem_q[wr_ptr_q] <= bus.lane_data[gi*DATA_W +: DATA_W];
      end
    end
  end

  // Output register FSM: load whenever every lane has a sample and the slot is free or being drained.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    load       = (&lane_nonempty) && ((state_q == S_EMPTY) || bus.out_ready);
    case (state_q)
      S_EMPTY: begin
        if (load) begin
          state_d    = S_FULL;
          out_data_d = head_data;
        end
      end
      S_FULL: begin
        if (load) begin
          out_data_d = head_data;
        end else if (bus.out_ready) begin
          state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Output register state and data. A flush drops any pending word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      out_data_q <= '0;
    end else if (bus.flush) begin
      state_q    <= S_EMPTY;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
    end
  end

  assign bus.out_valid = (state_q == S_FULL);
  assign bus.out_data  = out_data_q;

`ifdef RESNET88_COLLECTOR_STATS_EN
  logic [LANES-1:0] overflow_q, overflow_d;
  logic [31:0]      word_count_q, word_count_d;

  // A sample is lost when its lane is full and no pop happens on that edge.
  always_comb begin
    overflow_d   = overflow_q | (bus.lane_valid & lane_full & {LANES{~load}});
    word_count_d = word_count_q;
    if ((state_q == S_FULL) && bus.out_ready) word_count_d = word_count_q + 32'd1;
  end

  // Sticky overflow flags and the accepted-word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q   <= '0;
      word_count_q <= '0;
    end else if (bus.flush) begin
      overflow_q   <= '0;
      word_count_q <= '0;
    end else begin
      overflow_q   <= overflow_d;
      word_count_q <= word_count_d;
    end
  end

  assign bus.overflow   = overflow_q;
  assign bus.word_count = word_count_q;
`else
  assign bus.overflow   = '0;
  assign bus.word_count = '0;
`endif

endmodule
